// File: rtl/functional_issue_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the Functional-unit issue controller.
`default_nettype none

package functional_issue_ctrl_pkg;

   localparam int DEF_DEPTH = 4;
   localparam int DEF_W     = 2;
   localparam int DEF_IW    = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/functional_instr_fifo.sv
// Instruction FIFO for the issue controller: DEPTH entries, power-of-2 pointers wrap naturally.
`default_nettype none

module functional_instr_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; validity is tracked entirely by count/pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

`default_nettype wire

// File: rtl/functional_issue_ctrl.sv
// Issue stage for the 2-bit Functional unit: FIFO-buffered ops, one settle cycle, valid/ready result.
// Optional FUNC_ACC_FWD_EN: fwd=1 instructions take operand A from the last captured result.
`default_nettype none

module functional_issue_ctrl
   import functional_issue_ctrl_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_W,
   parameter int IW    = DEF_IW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IW+2*W:0]   in_instr,
   output logic [W-1:0]      fu_a,
   output logic [W-1:0]      fu_b,
   output logic [IW-1:0]     fu_i,
   input  logic [W-1:0]      fu_f,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_data,
   output logic [IW-1:0]     res_op,
   output logic              busy
);

   localparam int IR_W    = IW + 2*W + 1;
   localparam int B_LSB   = 0;
   localparam int A_LSB   = W;
   localparam int I_LSB   = 2*W;
   localparam int FWD_BIT = IW + 2*W;

   state_t          state_q, state_d;
   logic [W-1:0]    fu_a_q, fu_a_d;
   logic [W-1:0]    fu_b_q, fu_b_d;
   logic [IW-1:0]   fu_i_q, fu_i_d;
   logic            res_valid_q, res_valid_d;
   logic [W-1:0]    res_data_q, res_data_d;
   logic [IW-1:0]   res_op_q, res_op_d;

   logic [IR_W-1:0] head;
   logic            fifo_full, fifo_empty, load;
   logic [W-1:0]    head_a;

   functional_instr_fifo #(
      .DEPTH (DEPTH),
      .DW    (IR_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid & in_ready),
      .pop   (load),
      .wdata (in_instr),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef FUNC_ACC_FWD_EN
   assign head_a = head[FWD_BIT] ? res_data_q : head[A_LSB +: W];
`else
   logic w_unused_fwd;
   assign w_unused_fwd = head[FWD_BIT];
   assign head_a       = head[A_LSB +: W];
`endif

   always_comb begin
      state_d     = state_q;
      fu_a_d      = fu_a_q;
      fu_b_d      = fu_b_q;
      fu_i_d      = fu_i_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
      load        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) load = 1'b1;
         end
         ST_ISSUE: begin
            res_data_d  = fu_f;
            res_op_d    = fu_i_q;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) load = 1'b1;
               else             state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A pop always launches a fresh op; fu_* otherwise hold their last values.
      if (load) begin
         fu_a_d  = head_a;
         fu_b_d  = head[B_LSB +: W];
         fu_i_d  = head[I_LSB +: IW];
         state_d = ST_ISSUE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fu_a_q      <= '0;
         fu_b_q      <= '0;
         fu_i_q      <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
      end else begin
         state_q     <= state_d;
         fu_a_q      <= fu_a_d;
         fu_b_q      <= fu_b_d;
         fu_i_q      <= fu_i_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
      end
   end

   assign in_ready  = ~fifo_full;
   assign fu_a      = fu_a_q;
   assign fu_b      = fu_b_q;
   assign fu_i      = fu_i_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
   assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_functional_issue_ctrl.sv
// Bench for functional_issue_ctrl: Functional-unit stand-in, in-order result scoreboard, directed vectors.
`default_nettype none

module tb_functional_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [6:0] in_instr = '0;
   logic       in_ready, res_valid, busy;
   logic [1:0] fu_a, fu_b, fu_i, fu_f, res_data, res_op;

   int n_checks = 0;
   int n_fail = 0;
   int n_results = 0;
   int cyc = 0;

   typedef struct {
      logic [1:0] op;
      logic [1:0] data;
   } exp_t;
   exp_t       exp_q[$];
   exp_t       e;
   logic [1:0] last_res = '0;
   logic [1:0] a_sel;
   logic       prev_hold = 1'b0;
   logic [3:0] prev_pair = '0;

   // Functional unit stand-in: 00 AND, 01 OR, 10 ADD mod 4, 11 XOR.
   function automatic logic [1:0] fu_model(input logic [1:0] i, input logic [1:0] a,
                                           input logic [1:0] b);
      case (i)
         2'b00:   return a & b;
         2'b01:   return a | b;
         2'b10:   return a + b;
         default: return a ^ b;
      endcase
   endfunction

   assign fu_f = fu_model(fu_i, fu_a, fu_b);

   functional_issue_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .fu_a      (fu_a),
      .fu_b      (fu_b),
      .fu_i      (fu_i),
      .fu_f      (fu_f),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted instructions become expected results in program order.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         last_res  = '0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            check("hold_valid", res_valid, 1);
            check("hold_stable", {res_op, res_data}, prev_pair);
         end
         if (in_valid && in_ready) begin
`ifdef FUNC_ACC_FWD_EN
            a_sel = in_instr[6] ? last_res : in_instr[3:2];
`else
            a_sel = in_instr[3:2];
`endif
            last_res = fu_model(in_instr[5:4], a_sel, in_instr[1:0]);
            exp_q.push_back('{op: in_instr[5:4], data: last_res});
         end
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL res_unexpected: got op %0h data %0h with nothing outstanding",
                        res_op, res_data);
            end else begin
               e = exp_q.pop_front();
               check("res_op", res_op, e.op);
               check("res_data", res_data, e.data);
               n_results++;
            end
         end
         prev_hold = res_valid && !res_ready;
         prev_pair = {res_op, res_data};
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic push(input logic [6:0] ins);
      in_valid = 1'b1;
      in_instr = ins;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      check("push_ready", in_ready, 1);
      if (in_ready) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!busy && !res_valid) break;
      end
      check(name, {busy, res_valid}, 2'b00);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int start;
      int got0;

      // Power-on reset state
      #1;
      check("rst_res_valid", res_valid, 0);
      check("rst_fu", {fu_i, fu_a, fu_b}, 6'b0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Async reset while holding a result with one op buffered
      res_ready = 1'b0;
      push(7'b0_11_11_01);
      push(7'b0_10_01_10);
      @(posedge clk);
      #1;
      check("pre_rst_valid", res_valid, 1);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_fu", {fu_i, fu_a, fu_b}, 6'b0);
      check("mid_rst_res", {res_op, res_data}, 4'b0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      res_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("post_rst_quiet", {busy, res_valid}, 2'b00);

      // Single op: OR(10,11) = 11
      push(7'b0_01_10_11);
      check("single_e0_valid", res_valid, 0);
      @(posedge clk);
      #1;
      check("single_fu", {fu_i, fu_a, fu_b}, 6'b01_10_11);
      check("single_e1_valid", res_valid, 0);
      @(posedge clk);
      #1;
      check("single_e2_valid", res_valid, 1);
      check("single_res", {res_op, res_data}, 4'b01_11);
      wait_idle("single_idle");
      check("fu_hold_idle", {fu_i, fu_a, fu_b}, 6'b01_10_11);

      // Fill: 1 issued + 4 buffered, then back-pressure for 10 cycles
      res_ready = 1'b0;
      push(7'b0_00_11_10);
      push(7'b0_01_01_10);
      push(7'b0_10_11_11);
      push(7'b0_11_10_01);
      push(7'b0_10_01_01);
      check("full_in_ready", in_ready, 0);
      check("full_res", {res_valid, res_op, res_data}, 5'b1_00_10);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         check("bp_in_ready", in_ready, 0);
         check("bp_res", {res_valid, res_op, res_data}, 5'b1_00_10);
         check("bp_fu", {fu_i, fu_a, fu_b}, 6'b00_11_10);
      end
      res_ready = 1'b1;
      push(7'b0_00_10_11);
      wait_idle("full_drain");

      // Sweep all I/A/B combinations at full rate
      got0  = n_results;
      start = cyc;
      for (int i = 0; i < 64; i++) push({1'b0, 6'(i)});
      wait_idle("sweep_drain");
      check("sweep_count", n_results - got0, 64);
      check("sweep_rate", (cyc - start) > 140, 0);

      // Forwarding: ADD(01,01) = 10, then fwd OR with A=00, B=00
      push(7'b0_10_01_01);
      wait_idle("fwd_op1");
      check("fwd_r", res_data, 2'b10);
      push(7'b1_01_00_00);
      @(posedge clk);
      #1;
`ifdef FUNC_ACC_FWD_EN
      check("fwd_fu_a", fu_a, 2'b10);
`else
      check("fwd_fu_a", fu_a, 2'b00);
`endif
      check("fwd_fu_i", fu_i, 2'b01);
      @(posedge clk);
      #1;
`ifdef FUNC_ACC_FWD_EN
      check("fwd_res", res_data, 2'b10);
`else
      check("fwd_res", res_data, 2'b00);
`endif
      wait_idle("fwd_drain");
      check("sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
